apb_slave_mem: RTL and testbench

APB_SLAVE_MEM -- requirements
Module: apb_slave_mem

---
 rtl/apb_slave_mem.sv | 123 ++++++++++++
 tb/tb_apb_slave_mem.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/apb_slave_mem.sv
// APB3 slave with a DEPTH x 8-bit register-file memory and a fixed number of
// access-phase wait states. Out-of-range addresses answer with PSLVERR.
module apb_slave_mem #(
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic       PCLK,
  input  logic       PRESET,
  input  logic       PSEL,
  input  logic       PENABLE,
  input  logic       PWRITE,
  input  logic [8:0] PADDR,
  input  logic [7:0] PWDATA,
  output logic [7:0] PRDATA,
  output logic       PREADY,
  output logic       PSLVERR,
  output logic       o_dbg_state
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Handshake: a transfer is accepted in IDLE on a setup cycle (PSEL=1,
  // PENABLE=0); it completes in the access cycle where PREADY=1, which is the
  // only cycle in which PSLVERR and read PRDATA carry meaning. Dropping PSEL
  // while in ACCESS abandons the transfer without side effects.
  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACCESS = 1'b1
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_next;
  logic [7:0] r_addr;
  logic       r_write;
  logic [7:0] r_wdata;
  logic [7:0] r_rdata;
  logic [7:0] r_mem [DEPTH];

  logic       w_setup;
  logic       w_ready;
  logic       w_err;
  logic       w_paddr_err;
  logic       w_commit;
  logic [7:0] w_rd_byte;

  assign w_err       = {1'b0, r_addr} >= 9'(DEPTH);
  assign w_paddr_err = {1'b0, PADDR[7:0]} >= 9'(DEPTH);
  assign w_rd_byte   = w_paddr_err ? 8'h00 : r_mem[PADDR[AW-1:0]];
  assign w_commit    = w_ready && r_write && !w_err;

  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    w_setup    = 1'b0;
    w_ready    = 1'b0;
    case (r_state)
      S_IDLE: begin
        // PENABLE without a preceding setup is not a transfer.
        if (PSEL && !PENABLE) begin
          w_setup    = 1'b1;
          w_next     = S_ACCESS;
          w_cnt_next = 4'(WAIT_CYCLES);
        end
      end
      S_ACCESS: begin
        if (!PSEL) begin
          w_next     = S_IDLE;
          w_cnt_next = 4'd0;
        end else if (PENABLE) begin
          if (r_cnt == 4'd0) begin
            w_ready = 1'b1;
            w_next  = S_IDLE;
          end else begin
            w_cnt_next = r_cnt - 4'd1;
          end
        end
      end
      default: begin
        w_next     = S_IDLE;
        w_cnt_next = 4'd0;
      end
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_addr  <= 8'h00;
      r_write <= 1'b0;
      r_wdata <= 8'h00;
      r_rdata <= 8'h00;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      if (w_setup) begin
        r_addr  <= PADDR[7:0];
        r_write <= PWRITE;
        r_wdata <= PWDATA;
        r_rdata <= w_rd_byte;
      end
    end
  end

  // The store is cleared by reset as a whole, so it lives in flops.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= 8'h00;
      end
    end else if (w_commit) begin
      r_mem[r_addr[AW-1:0]] <= r_wdata;
    end
  end

  assign PREADY      = w_ready;
  assign PSLVERR     = w_ready && w_err;
  assign PRDATA      = r_rdata;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Bench for apb_slave_mem: one instance with 2 wait states, one with none,
// sharing a driven bus; a select bit steers PSEL and the observed outputs.
module tb_apb_slave_mem;

  logic       clk = 1'b0;
  logic       preset;
  logic       psel;
  logic       penable;
  logic       pwrite;
  logic [8:0] paddr;
  logic [7:0] pwdata;
  logic       use0;

  logic       psel_a, psel_b;
  logic [7:0] prdata_a, prdata_b, prdata;
  logic       pready_a, pready_b, pready;
  logic       pslverr_a, pslverr_b, pslverr;
  logic       state_a, state_b, state;

  always #5 clk = ~clk;

  assign psel_a  = psel & ~use0;
  assign psel_b  = psel & use0;
  assign prdata  = use0 ? prdata_b  : prdata_a;
  assign pready  = use0 ? pready_b  : pready_a;
  assign pslverr = use0 ? pslverr_b : pslverr_a;
  assign state   = use0 ? state_b   : state_a;

  apb_slave_mem #(.DEPTH(64), .WAIT_CYCLES(2)) dut (
    .PCLK(clk), .PRESET(preset), .PSEL(psel_a), .PENABLE(penable),
    .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata_a),
    .PREADY(pready_a), .PSLVERR(pslverr_a), .o_dbg_state(state_a)
  );

  apb_slave_mem #(.DEPTH(64), .WAIT_CYCLES(0)) dut0 (
    .PCLK(clk), .PRESET(preset), .PSEL(psel_b), .PENABLE(penable),
    .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata_b),
    .PREADY(pready_b), .PSLVERR(pslverr_b), .o_dbg_state(state_b)
  );

  typedef struct {
    logic       wr;
    logic [8:0] addr;
    logic [7:0] wd;
    logic [7:0] exp_rd;
    logic       exp_err;
  } vec_t;

  vec_t       vecs[12];
  logic [7:0] exp_mem[64];
  logic [7:0] exp_q[$];
  int         n_tests = 0;
  int         n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One transfer; address/data are scrambled during the access phase,
  // which the slave must ignore. Returns the access-phase length in cycles.
  task automatic apb_xfer(input logic wr, input logic [8:0] addr, input logic [7:0] wd,
                          output logic [7:0] rd, output logic err, output int cyc);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd;
    @(negedge clk);
    penable = 1'b1; pwdata = ~wd; paddr = addr ^ 9'h001;
    cyc = 1;
    #1;
    while (!pready && cyc < 32) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    rd  = prdata;
    err = pslverr;
  endtask

  task automatic bus_idle();
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic scan(input string name);
    logic [7:0] rd;
    logic       err;
    int         cyc;
    for (int i = 0; i < 64; i++) exp_q.push_back(exp_mem[i]);
    for (int i = 0; i < 64; i++) begin
      apb_xfer(1'b0, 9'(i), 8'h00, rd, err, cyc);
      check($sformatf("%s[%0d]", name, i), {24'h0, rd}, {24'h0, exp_q.pop_front()});
    end
    bus_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] rd;
    logic       err;
    int         cyc;

    vecs[0]  = '{1'b1, 9'h012, 8'h5A, 8'h00, 1'b0};
    vecs[1]  = '{1'b0, 9'h012, 8'h00, 8'h5A, 1'b0};
    vecs[2]  = '{1'b1, 9'h040, 8'hFF, 8'h00, 1'b1};
    vecs[3]  = '{1'b0, 9'h040, 8'h00, 8'h00, 1'b1};
    vecs[4]  = '{1'b1, 9'h105, 8'h33, 8'h00, 1'b0};
    vecs[5]  = '{1'b0, 9'h005, 8'h00, 8'h33, 1'b0};
    vecs[6]  = '{1'b1, 9'h03F, 8'hC3, 8'h00, 1'b0};
    vecs[7]  = '{1'b0, 9'h03F, 8'h00, 8'hC3, 1'b0};
    vecs[8]  = '{1'b0, 9'h000, 8'h00, 8'h00, 1'b0};
    vecs[9]  = '{1'b0, 9'h0FF, 8'h00, 8'h00, 1'b1};
    vecs[10] = '{1'b1, 9'h008, 8'h11, 8'h00, 1'b0};
    vecs[11] = '{1'b0, 9'h008, 8'h00, 8'h11, 1'b0};
    for (int i = 0; i < 64; i++) exp_mem[i] = 8'h00;

    preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = 9'h000; pwdata = 8'h00; use0 = 1'b0;
    #12;
    check("rst_prdata", {24'h0, prdata_a}, 32'h0);
    check("rst_pready", {31'h0, pready_a}, 32'h0);
    check("rst_pslverr", {31'h0, pslverr_a}, 32'h0);
    check("rst_state", {31'h0, state_a}, 32'h0);
    check("rst_state0", {31'h0, state_b}, 32'h0);
    @(negedge clk);
    preset = 1'b0;

    // Table vectors on the 2-wait-state instance.
    for (int i = 0; i < 12; i++) begin
      apb_xfer(vecs[i].wr, vecs[i].addr, vecs[i].wd, rd, err, cyc);
      check($sformatf("vec%0d_cycles", i), 32'(cyc), 32'd3);
      check($sformatf("vec%0d_err", i), {31'h0, err}, {31'h0, vecs[i].exp_err});
      if (!vecs[i].wr)
        check($sformatf("vec%0d_rdata", i), {24'h0, rd}, {24'h0, vecs[i].exp_rd});
      if (vecs[i].wr && !vecs[i].exp_err)
        exp_mem[vecs[i].addr[5:0]] = vecs[i].wd;
    end
    bus_idle();
    scan("scan_after_table");

    // Zero-wait instance: back-to-back write then read.
    use0 = 1'b1;
    apb_xfer(1'b1, 9'h003, 8'hA5, rd, err, cyc);
    check("w0_wr_cycles", 32'(cyc), 32'd1);
    check("w0_wr_err", {31'h0, err}, 32'h0);
    apb_xfer(1'b0, 9'h003, 8'h00, rd, err, cyc);
    check("w0_rd_cycles", 32'(cyc), 32'd1);
    check("w0_rd_data", {24'h0, rd}, 32'hA5);
    bus_idle();
    use0 = 1'b0;

    // Master abort in the 2nd access cycle of a write.
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 9'h008; pwdata = 8'h77;
    @(negedge clk);
    penable = 1'b1;
    #1;
    check("abort_acc1_ready", {31'h0, pready}, 32'h0);
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
    #1;
    check("abort_state_before", {31'h0, state}, 32'h1);
    check("abort_ready", {31'h0, pready}, 32'h0);
    check("abort_err", {31'h0, pslverr}, 32'h0);
    @(posedge clk);
    #1;
    check("abort_state_after", {31'h0, state}, 32'h0);
    apb_xfer(1'b0, 9'h008, 8'h00, rd, err, cyc);
    check("abort_readback", {24'h0, rd}, {24'h0, exp_mem[8]});
    bus_idle();

    // PENABLE with PSEL but no setup must not start a transfer.
    @(negedge clk);
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 9'h008; pwdata = 8'hEE;
    @(negedge clk);
    #1;
    check("noset_state", {31'h0, state}, 32'h0);
    check("noset_ready", {31'h0, pready}, 32'h0);
    bus_idle();

    // Asynchronous reset in the PREADY cycle of a write.
    apb_xfer(1'b0, 9'h012, 8'h00, rd, err, cyc);
    check("pre_rst_read", {24'h0, rd}, 32'h5A);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 9'h012; pwdata = 8'h99;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("mid_ready_before_rst", {31'h0, pready}, 32'h1);
    #2;
    preset = 1'b1;
    #1;
    check("arst_ready", {31'h0, pready}, 32'h0);
    check("arst_err", {31'h0, pslverr}, 32'h0);
    check("arst_prdata", {24'h0, prdata}, 32'h0);
    check("arst_state", {31'h0, state}, 32'h0);
    psel = 1'b0; penable = 1'b0;
    for (int i = 0; i < 64; i++) exp_mem[i] = 8'h00;

    // Release reset while clock is high; setup must land on the next edge.
    @(posedge clk);
    #2;
    preset = 1'b0;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 9'h021; pwdata = 8'hE7;
    @(posedge clk);
    #1;
    check("first_setup_state", {31'h0, state}, 32'h1);
    penable = 1'b1;
    cyc = 1;
    @(negedge clk);
    while (!pready && cyc < 32) begin
      @(negedge clk);
      cyc++;
    end
    check("first_xfer_cycles", 32'(cyc), 32'd3);
    exp_mem[8'h21] = 8'hE7;
    bus_idle();
    scan("scan_after_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
